pleiads_rom_loader: RTL



---
 rtl/pleiads_dl_pkg.sv | 36 +++
 rtl/pleiads_rom_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pleiads_dl_pkg.sv
// Shared types for the Pleiads ROM download path: FSM states, ROM region codes
// and the address-to-region decode used on the core write port.
package pleiads_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    REGION_PROG = 2'd0,
    REGION_BG   = 2'd1,
    REGION_FG   = 2'd2,
    REGION_PROM = 2'd3
  } region_t;

  localparam logic [24:0] REGION_BG_BASE   = 25'h0_4000;
  localparam logic [24:0] REGION_FG_BASE   = 25'h0_5000;
  localparam logic [24:0] REGION_PROM_BASE = 25'h0_6000;

  // Everything at or above the PROM base decodes as PROM; the loader
  // range-checks against the image size before this is ever used.
  function automatic region_t region_of(input logic [24:0] addr);
    region_t r;
    if (addr < REGION_BG_BASE)        r = REGION_PROG;
    else if (addr < REGION_FG_BASE)   r = REGION_BG;
    else if (addr < REGION_PROM_BASE) r = REGION_FG;
    else                              r = REGION_PROM;
    return r;
  endfunction

endpackage

// File: rtl/pleiads_rom_loader.sv
// ROM download front end for the phoenix core: range-checks ioctl bytes, forwards
// them to dn_* one cycle later and owns core reset. Option: PLEIADS_ROM_LOADER_CHECKSUM_EN.
module pleiads_rom_loader
  import pleiads_dl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int EXPECTED_BYTES = 25088,
  parameter int HOLD_CYCLES    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
  input  logic [15:0]       expected_sum,
  output logic [15:0]       checksum,
`endif
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [1:0]        dn_region,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              err_size,
  output logic              err_range,
  output state_t            dbg_state
);

  localparam logic [25:0] EXP_CNT  = 26'(EXPECTED_BYTES);
  localparam logic [24:0] EXP_ADDR = 25'(EXPECTED_BYTES);
  localparam int          HW       = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state;
  logic          download_d;
  logic [25:0]   byte_cnt;
  logic [HW-1:0] hold_cnt;

  logic dl_rise;
  logic accept;
  logic in_range;
  logic fwd;
  logic sum_ok;

  // Handshake: there is no backpressure anywhere. ioctl_wr is a one-cycle
  // strobe taken only while in LOAD (which includes the cycle ioctl_download
  // falls); dn_wr is a one-cycle strobe the core must take, and dn_addr,
  // dn_data and dn_region are only meaningful while dn_wr is high.
  assign dl_rise  = ioctl_download & ~download_d;
  assign accept   = ioctl_wr && (state == ST_LOAD);
  assign in_range = (ioctl_addr < EXP_ADDR);
  assign fwd      = accept && in_range;

`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
  assign sum_ok = (checksum == expected_sum);
`else
  assign sum_ok = 1'b1;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      download_d   <= 1'b0;
      byte_cnt     <= '0;
      hold_cnt     <= '0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_wr        <= 1'b0;
      dn_region    <= '0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      err_size     <= 1'b0;
      err_range    <= 1'b0;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      download_d <= ioctl_download;
      dn_wr      <= 1'b0;

      if (fwd) begin
        dn_wr     <= 1'b1;
        dn_addr   <= ioctl_addr[ADDR_W-1:0];
        dn_data   <= ioctl_dout;
        dn_region <= region_of(ioctl_addr);
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        checksum  <= checksum + {8'h00, ioctl_dout};
`endif
      end

      // Out-of-range bytes are still counted so an oversize image fails on size too.
      if (accept) begin
        if (!in_range)
          err_range <= 1'b1;
        if (byte_cnt != '1)
          byte_cnt <= byte_cnt + 26'd1;
      end

      if (dl_rise) begin
        state        <= ST_LOAD;
        byte_cnt     <= '0;
        err_size     <= 1'b0;
        err_range    <= 1'b0;
        load_done    <= 1'b0;
        core_reset_n <= 1'b0;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        checksum     <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: core_reset_n <= 1'b0;
          ST_LOAD: begin
            core_reset_n <= 1'b0;
            if (!ioctl_download)
              state <= ST_CHECK;
          end
          ST_CHECK: begin
            if ((byte_cnt == EXP_CNT) && !err_range && sum_ok) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else begin
              err_size <= (byte_cnt != EXP_CNT) || !sum_ok;
              state    <= ST_FAIL;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state        <= ST_RUN;
              core_reset_n <= 1'b1;
              load_done    <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          ST_RUN: begin
            core_reset_n <= 1'b1;
            load_done    <= 1'b1;
          end
          ST_FAIL: begin
            core_reset_n <= 1'b0;
            load_done    <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // The core may only leave reset in RUN, and load_done tracks it exactly.
  a_reset_only_in_run: assert property (@(posedge clk) disable iff (!reset_n)
    core_reset_n |-> (state == ST_RUN));
  a_done_matches_reset: assert property (@(posedge clk) disable iff (!reset_n)
    load_done == core_reset_n);

endmodule
